i2c_reg_bank: RTL and testbench

Parametrised register bank and FIFO front-end for the I2C controller. It implements the full register map at offsets 0x01C–0x144 behind a simple single-beat register bus. It adds a configurable TX/RX FIFO depth, a configurable GPO width and an RX programmable-threshold interrupt. The bank sits between the host bus bridge and the I2C bit/byte engine, which consumes TX entries, pushes RX bytes and reports events and status.

---
 rtl/i2c_reg_bank_pkg.sv | 75 +++++++
 rtl/i2c_sync_fifo.sv | 56 +++++
 rtl/i2c_reg_bank.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_reg_bank.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_bank_pkg.sv
// Shared definitions for the I2C register bank: register offsets, packed
// register layouts and small helpers used by the bank and its FIFOs.
package i2c_reg_bank_pkg;

  // Byte offsets of the register map (bits [1:0] are always zero).
  localparam logic [8:0] ADDR_GIE     = 9'h01C;
  localparam logic [8:0] ADDR_ISR     = 9'h020;
  localparam logic [8:0] ADDR_IER     = 9'h028;
  localparam logic [8:0] ADDR_SOFTR   = 9'h040;
  localparam logic [8:0] ADDR_CR      = 9'h100;
  localparam logic [8:0] ADDR_SR      = 9'h104;
  localparam logic [8:0] ADDR_TX_FIFO = 9'h108;
  localparam logic [8:0] ADDR_RX_FIFO = 9'h10C;
  localparam logic [8:0] ADDR_ADR     = 9'h110;
  localparam logic [8:0] ADDR_TX_OCY  = 9'h114;
  localparam logic [8:0] ADDR_RX_OCY  = 9'h118;
  localparam logic [8:0] ADDR_TEN_ADR = 9'h11C;
  localparam logic [8:0] ADDR_RX_PIRQ = 9'h120;
  localparam logic [8:0] ADDR_GPO     = 9'h124;
  localparam logic [8:0] ADDR_TSUSTA  = 9'h128;

  // Eight consecutive timing registers starting at TSUSTA:
  // TSUSTA, TSUSTO, THDSTA, TSUDAT, TBUF, THIGH, TLOW, THDDAT.
  localparam int NUM_TIMING = 8;

  // Only this key value in SOFTR[3:0] starts a soft reset.
  localparam logic [3:0] SOFTR_KEY = 4'hA;

  typedef struct packed {
    logic gc_en;
    logic rsta;
    logic txak;
    logic tx;
    logic msms;
    logic tx_fifo_rst;
    logic en;
  } cr_t;

  typedef struct packed {
    logic       tx_empty;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_full;
    logic [3:0] sts;
  } sr_t;

  // Shared layout of ISR and IER.
  typedef struct packed {
    logic tx_half;
    logic nas;
    logic aas;
    logic bnb;
    logic rx_thr;
    logic tx_empty;
    logic tx_err;
    logic arb_lost;
  } isr_t;

  typedef struct packed {
    logic       stop;
    logic       start;
    logic [7:0] data;
  } tx_entry_t;

  // Width of the occupancy / threshold fields for a given FIFO depth.
  function automatic int occ_w(input int depth);
    return $clog2(depth);
  endfunction

  // Byte offset of timing register idx (0..7).
  function automatic logic [8:0] timing_addr(input int idx);
    return ADDR_TSUSTA + 9'(idx * 4);
  endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pop on empty is ignored; a push on
// a full FIFO is accepted only when a pop frees a slot in the same cycle.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt_q;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank and FIFO front-end of the I2C controller: decodes the
// single-beat register bus, holds control/timing registers, the TX/RX FIFOs,
// the interrupt status logic and the keyed soft reset.
module i2c_reg_bank
  import i2c_reg_bank_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          GPO_W      = 12,
  parameter logic [31:0] TIMING_RST = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [8:0]       req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [6:0]       cr_o,
  output logic [6:0]       adr_o,
  output logic [2:0]       ten_adr_o,
  output logic [GPO_W-1:0] gpo_o,
  output logic [31:0]      tsusta_o,
  output logic [31:0]      tsusto_o,
  output logic [31:0]      thdsta_o,
  output logic [31:0]      tsudat_o,
  output logic [31:0]      tbuf_o,
  output logic [31:0]      thigh_o,
  output logic [31:0]      tlow_o,
  output logic [31:0]      thddat_o,
  output logic             tx_valid_o,
  output logic [9:0]       tx_data_o,
  input  logic             tx_pop_i,
  input  logic             rx_push_i,
  input  logic [7:0]       rx_data_i,
  output logic             rx_full_o,
  input  logic [4:0]       evt_i,
  input  logic [3:0]       sts_i,
  output logic             soft_rst_o,
  output logic             irq_o
);

  localparam int          OW      = occ_w(FIFO_DEPTH);
  localparam logic [OW:0] TX_HALF = (OW+1)'(FIFO_DEPTH / 2);

  // Bus protocol: the bank is always ready, so every cycle with req_valid=1
  // is one accepted request. Exactly one cycle later rsp_valid=1 for one
  // cycle with rsp_rdata (0 for writes) and rsp_err (unmapped offset).
  // There is no back-pressure on either side.

  logic        soft_rst_q;
  logic        rst_all;
  logic [8:0]  word;
  logic        wr_en;
  logic        rd_en;

  logic        gie_q;
  logic [7:0]  isr_q;
  logic [7:0]  ier_q;
  cr_t         cr_q;
  logic [6:0]  adr_q;
  logic [2:0]  ten_adr_q;
  logic [OW-1:0]    pirq_q;
  logic [GPO_W-1:0] gpo_q;
  logic [31:0] timing_q [NUM_TIMING];
  logic        irq_q;

  isr_t        isr_set;
  logic [7:0]  isr_tgl;
  logic [7:0]  isr_next;
  sr_t         sr;

  tx_entry_t   tx_head;
  logic        tx_push, tx_clr, tx_full, tx_empty;
  logic [OW:0] tx_count, tx_ocy;
  logic [7:0]  rx_head;
  logic        rx_pop, rx_full, rx_empty;
  logic [OW:0] rx_count, rx_ocy;

  logic [31:0] rdata;
  logic        mapped;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        unused_bits;

  assign word    = {req_addr[8:2], 2'b00};
  assign wr_en   = req_valid & req_we;
  assign rd_en   = req_valid & ~req_we;
  assign rst_all = rst | soft_rst_q;

  // The TX FIFO is held empty while CR.TX_FIFO_Reset is set.
  assign tx_clr  = rst_all | cr_q.tx_fifo_rst;
  assign tx_push = wr_en & (word == ADDR_TX_FIFO) & ~tx_full & ~cr_q.tx_fifo_rst;
  assign rx_pop  = rd_en & (word == ADDR_RX_FIFO);

  i2c_sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .clr   (tx_clr),
    .push  (tx_push),
    .wdata (req_wdata[9:0]),
    .pop   (tx_pop_i),
    .rdata (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .clr   (rst_all),
    .push  (rx_push_i),
    .wdata (rx_data_i),
    .pop   (rx_pop),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign sr     = {tx_empty, rx_empty, rx_full, tx_full, sts_i};
  assign tx_ocy = (tx_count == '0) ? '0 : tx_count - (OW+1)'(1);
  assign rx_ocy = (rx_count == '0) ? '0 : rx_count - (OW+1)'(1);

  // Interrupt status sources; a source at 1 sets its ISR bit that cycle.
  always_comb begin
    isr_set          = '0;
    isr_set.arb_lost = evt_i[0];
    isr_set.tx_err   = evt_i[1];
    isr_set.tx_empty = tx_empty;
    isr_set.rx_thr   = (rx_count >= ({1'b0, pirq_q} + (OW+1)'(1)));
    isr_set.bnb      = evt_i[2];
    isr_set.aas      = evt_i[3];
    isr_set.nas      = evt_i[4];
    isr_set.tx_half  = (tx_count <= TX_HALF);
  end

  // Writing 1 toggles an ISR bit; applying the set afterwards makes set win.
  assign isr_tgl  = (wr_en && word == ADDR_ISR) ? req_wdata[7:0] : 8'h00;
  assign isr_next = (isr_q ^ isr_tgl) | isr_set;

  // Soft reset strobe: one cycle, only for the correct key.
  always_ff @(posedge clk) begin
    if (rst) soft_rst_q <= 1'b0;
    else     soft_rst_q <= wr_en & (word == ADDR_SOFTR) & (req_wdata[3:0] == SOFTR_KEY);
  end

  // Read/write control, status and timing registers.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      gie_q     <= 1'b0;
      isr_q     <= '0;
      ier_q     <= '0;
      cr_q      <= '0;
      adr_q     <= '0;
      ten_adr_q <= '0;
      pirq_q    <= '0;
      gpo_q     <= '0;
      for (int i = 0; i < NUM_TIMING; i++) timing_q[i] <= TIMING_RST;
    end else begin
      isr_q <= isr_next;
      if (wr_en) begin
        case (word)
          ADDR_GIE:     gie_q     <= req_wdata[31];
          ADDR_IER:     ier_q     <= req_wdata[7:0];
          ADDR_CR:      cr_q      <= cr_t'(req_wdata[6:0]);
          ADDR_ADR:     adr_q     <= req_wdata[6:0];
          ADDR_TEN_ADR: ten_adr_q <= req_wdata[2:0];
          ADDR_RX_PIRQ: pirq_q    <= req_wdata[OW-1:0];
          ADDR_GPO:     gpo_q     <= req_wdata[GPO_W-1:0];
          default:      ;
        endcase
        for (int i = 0; i < NUM_TIMING; i++) begin
          if (word == timing_addr(i)) timing_q[i] <= req_wdata;
        end
      end
    end
  end

  // Registered interrupt: one cycle behind the ISR/IER/GIE state.
  always_ff @(posedge clk) begin
    if (rst_all) irq_q <= 1'b0;
    else         irq_q <= gie_q & |(isr_q & ier_q);
  end

  // Read data mux and address decode; write-only offsets read as 0.
  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (word)
      ADDR_GIE:     rdata[31]       = gie_q;
      ADDR_ISR:     rdata[7:0]      = isr_q;
      ADDR_IER:     rdata[7:0]      = ier_q;
      ADDR_SOFTR:   ;
      ADDR_CR:      rdata[6:0]      = cr_q;
      ADDR_SR:      rdata[7:0]      = sr;
      ADDR_TX_FIFO: ;
      ADDR_RX_FIFO: rdata[7:0]      = rx_empty ? 8'h00 : rx_head;
      ADDR_ADR:     rdata[6:0]      = adr_q;
      ADDR_TX_OCY:  rdata[OW-1:0]   = tx_ocy[OW-1:0];
      ADDR_RX_OCY:  rdata[OW-1:0]   = rx_ocy[OW-1:0];
      ADDR_TEN_ADR: rdata[2:0]      = ten_adr_q;
      ADDR_RX_PIRQ: rdata[OW-1:0]   = pirq_q;
      ADDR_GPO:     rdata[GPO_W-1:0] = gpo_q;
      default:      mapped          = 1'b0;
    endcase
    for (int i = 0; i < NUM_TIMING; i++) begin
      if (word == timing_addr(i)) begin
        rdata  = timing_q[i];
        mapped = 1'b1;
      end
    end
  end

  // Registered bus response, one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= req_valid;
      rsp_rdata_q <= rd_en ? rdata : 32'h0;
      rsp_err_q   <= req_valid & ~mapped;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign cr_o       = cr_q;
  assign adr_o      = adr_q;
  assign ten_adr_o  = ten_adr_q;
  assign gpo_o      = gpo_q;
  assign tsusta_o   = timing_q[0];
  assign tsusto_o   = timing_q[1];
  assign thdsta_o   = timing_q[2];
  assign tsudat_o   = timing_q[3];
  assign tbuf_o     = timing_q[4];
  assign thigh_o    = timing_q[5];
  assign tlow_o     = timing_q[6];
  assign thddat_o   = timing_q[7];
  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_head;
  assign rx_full_o  = rx_full;
  assign soft_rst_o = soft_rst_q;
  assign irq_o      = irq_q;

  assign unused_bits = ^{req_addr[1:0], req_wdata, tx_ocy[OW], rx_ocy[OW]};

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: register-map tables plus hand-written
// sequences for FIFOs, interrupts, set-vs-toggle and soft reset.
module tb_i2c_reg_bank;
  import i2c_reg_bank_pkg::*;

  localparam logic [31:0] T_RST = 32'h0000_00C8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [6:0]  cr_o, adr_o;
  logic [2:0]  ten_adr_o;
  logic [11:0] gpo_o;
  logic [31:0] tsusta_o, tsusto_o, thdsta_o, tsudat_o, tbuf_o, thigh_o, tlow_o, thddat_o;
  logic        tx_valid_o, tx_pop_i, rx_push_i, rx_full_o, soft_rst_o, irq_o;
  logic [9:0]  tx_data_o;
  logic [7:0]  rx_data_i;
  logic [4:0]  evt_i;
  logic [3:0]  sts_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  i2c_reg_bank #(.FIFO_DEPTH(16), .GPO_W(12), .TIMING_RST(T_RST)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cr_o(cr_o), .adr_o(adr_o), .ten_adr_o(ten_adr_o), .gpo_o(gpo_o),
    .tsusta_o(tsusta_o), .tsusto_o(tsusto_o), .thdsta_o(thdsta_o), .tsudat_o(tsudat_o),
    .tbuf_o(tbuf_o), .thigh_o(thigh_o), .tlow_o(tlow_o), .thddat_o(thddat_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_pop_i(tx_pop_i),
    .rx_push_i(rx_push_i), .rx_data_i(rx_data_i), .rx_full_o(rx_full_o),
    .evt_i(evt_i), .sts_i(sts_i), .soft_rst_o(soft_rst_o), .irq_o(irq_o)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] exp;
    logic        err;
  } rd_vec_t;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } wr_vec_t;

  rd_vec_t rv[26];
  wr_vec_t wv[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One bus beat; samples the response 1 time unit after the capturing edge.
  task automatic bus(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic vld, output logic err);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    rd  = rsp_rdata;
    vld = rsp_valid;
    err = rsp_err;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wr(input logic [8:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic vld, err;
    bus(1'b1, addr, wd, rd, vld, err);
    check("wr_rsp", {vld, err, rd}, {1'b1, 1'b0, 32'h0});
  endtask

  task automatic rd_chk(input string name, input logic [8:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic vld, err;
    bus(1'b0, addr, 32'h0, rd, vld, err);
    check(name, {vld, err, rd}, {1'b1, 1'b0, exp});
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_push_i = 1'b1;
    rx_data_i = b;
    @(posedge clk); #1;
    rx_push_i = 1'b0;
  endtask

  task automatic tx_pop();
    tx_pop_i = 1'b1;
    @(posedge clk); #1;
    tx_pop_i = 1'b0;
  endtask

  task automatic evt_pulse(input logic [4:0] e);
    evt_i = e;
    @(posedge clk); #1;
    evt_i = '0;
  endtask

  initial begin
    logic [31:0] rd, v;
    logic vld, err;

    // Vector tables
    rv[0]  = '{ADDR_GIE,     32'h0,  1'b0};
    rv[1]  = '{ADDR_ISR,     32'h84, 1'b0};
    rv[2]  = '{ADDR_IER,     32'h0,  1'b0};
    rv[3]  = '{ADDR_SOFTR,   32'h0,  1'b0};
    rv[4]  = '{ADDR_CR,      32'h0,  1'b0};
    rv[5]  = '{ADDR_SR,      32'hC0, 1'b0};
    rv[6]  = '{ADDR_TX_FIFO, 32'h0,  1'b0};
    rv[7]  = '{ADDR_RX_FIFO, 32'h0,  1'b0};
    rv[8]  = '{ADDR_ADR,     32'h0,  1'b0};
    rv[9]  = '{ADDR_TX_OCY,  32'h0,  1'b0};
    rv[10] = '{ADDR_RX_OCY,  32'h0,  1'b0};
    rv[11] = '{ADDR_TEN_ADR, 32'h0,  1'b0};
    rv[12] = '{ADDR_RX_PIRQ, 32'h0,  1'b0};
    rv[13] = '{ADDR_GPO,     32'h0,  1'b0};
    for (int i = 0; i < 8; i++) rv[14+i] = '{9'(9'h128 + 4*i), T_RST, 1'b0};
    rv[22] = '{9'h000, 32'h0, 1'b1};
    rv[23] = '{9'h024, 32'h0, 1'b1};
    rv[24] = '{9'h148, 32'h0, 1'b1};
    rv[25] = '{9'h1FC, 32'h0, 1'b1};

    wv[0] = '{ADDR_GIE,     32'hFFFF_FFFF, 32'h8000_0000};
    wv[1] = '{ADDR_IER,     32'h0000_01FF, 32'h0000_00FF};
    wv[2] = '{ADDR_ADR,     32'hFFFF_FFFF, 32'h0000_007F};
    wv[3] = '{ADDR_TEN_ADR, 32'hFFFF_FFFF, 32'h0000_0007};
    wv[4] = '{ADDR_RX_PIRQ, 32'hFFFF_FFFF, 32'h0000_000F};
    wv[5] = '{ADDR_GPO,     32'hFFFF_FFFF, 32'h0000_0FFF};
    wv[6] = '{ADDR_CR,      32'h0000_FFFD, 32'h0000_007D};
    for (int i = 0; i < 8; i++)
      wv[7+i] = '{9'(9'h128 + 4*i), 32'hA5A5_0000 | 32'(i), 32'hA5A5_0000 | 32'(i)};

    // Reset
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    tx_pop_i = 1'b0; rx_push_i = 1'b0; rx_data_i = '0; evt_i = '0; sts_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {cr_o, adr_o, ten_adr_o, gpo_o, tx_valid_o, rx_full_o,
                          soft_rst_o, irq_o, rsp_valid}, 64'h0);
    check("rst_timing", {tsusta_o, thddat_o}, {T_RST, T_RST});
    rst = 1'b0;

    // Reset read-back of every offset, unmapped ones flag an error
    for (int i = 0; i < 26; i++) begin
      bus(1'b0, rv[i].addr, 32'h0, rd, vld, err);
      check($sformatf("reset_rd_%03h", rv[i].addr), {vld, err, rd}, {1'b1, rv[i].err, rv[i].exp});
    end
    @(posedge clk); #1;
    check("rsp_idle", rsp_valid, 1'b0);

    // Masked register writes and read-back
    for (int i = 0; i < 15; i++) begin
      wr(wv[i].addr, wv[i].wdata);
      rd_chk($sformatf("wr_rd_%03h", wv[i].addr), wv[i].addr, wv[i].exp);
    end
    check("reg_ports", {cr_o, adr_o, ten_adr_o, gpo_o}, {7'h7D, 7'h7F, 3'h7, 12'hFFF});
    check("timing_ports", {tsusta_o, thddat_o}, {32'hA5A5_0000, 32'hA5A5_0007});
    bus(1'b1, 9'h148, 32'hFFFF_FFFF, rd, vld, err);
    check("unmapped_wr", {vld, err, rd}, {1'b1, 1'b1, 32'h0});
    rd_chk("thddat_kept", 9'h144, 32'hA5A5_0007);
    wr(ADDR_IER, 32'h0);
    wr(ADDR_GIE, 32'h0);
    wr(ADDR_CR, 32'h0);

    // TX FIFO ordering and pops
    check("tx_valid_idle", tx_valid_o, 1'b0);
    wr(ADDR_TX_FIFO, 32'h1A5);
    check("tx_valid_1cyc", tx_valid_o, 1'b1);
    wr(ADDR_TX_FIFO, 32'h0FF);
    wr(ADDR_TX_FIFO, 32'h23C);
    rd_chk("tx_ocy_3", ADDR_TX_OCY, 32'h2);
    check("tx_head0", tx_data_o, 10'h1A5);
    tx_pop();
    check("tx_head1", {tx_valid_o, tx_data_o}, {1'b1, 10'h0FF});
    tx_pop();
    check("tx_head2", {tx_valid_o, tx_data_o}, {1'b1, 10'h23C});
    tx_pop();
    check("tx_drained", tx_valid_o, 1'b0);
    rd_chk("sr_tx_empty", ADDR_SR, 32'hC0);

    // RX overflow, drain, underflow
    for (int i = 0; i < 17; i++) rx_push(8'(8'h10 + i));
    check("rx_full", rx_full_o, 1'b1);
    rd_chk("sr_rx_full", ADDR_SR, 32'hA0);
    rd_chk("rx_ocy_full", ADDR_RX_OCY, 32'hF);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("rx_rd_%0d", i), ADDR_RX_FIFO, 32'(8'h10 + i));
    rd_chk("rx_rd_empty", ADDR_RX_FIFO, 32'h0);
    rd_chk("rx_ocy_empty", ADDR_RX_OCY, 32'h0);
    rd_chk("sr_rx_empty", ADDR_SR, 32'hC0);

    // Push during a read of an empty FIFO is kept
    rx_push_i = 1'b1; rx_data_i = 8'h77;
    bus(1'b0, ADDR_RX_FIFO, 32'h0, rd, vld, err);
    rx_push_i = 1'b0;
    check("rx_rd_push_empty", rd, 32'h0);
    rd_chk("rx_ocy_one", ADDR_RX_OCY, 32'h0);
    rd_chk("sr_rx_one", ADDR_SR, 32'h80);
    // Push and pop together keep the count
    rx_push_i = 1'b1; rx_data_i = 8'h31;
    bus(1'b0, ADDR_RX_FIFO, 32'h0, rd, vld, err);
    rx_push_i = 1'b0;
    check("rx_rd_push_pop", rd, 32'h77);
    rd_chk("rx_rd_after", ADDR_RX_FIFO, 32'h31);
    rd_chk("sr_rx_empty2", ADDR_SR, 32'hC0);

    // Threshold interrupt
    rd_chk("isr_sticky_thr", ADDR_ISR, 32'h8C);
    wr(ADDR_ISR, 32'h8C);
    rd_chk("isr_cleared", ADDR_ISR, 32'h84);
    wr(ADDR_RX_PIRQ, 32'h3);
    wr(ADDR_IER, 32'h08);
    wr(ADDR_GIE, 32'h8000_0000);
    check("irq_idle", irq_o, 1'b0);
    for (int i = 0; i < 4; i++) rx_push(8'(8'hA0 + i));
    check("irq_push_edge", irq_o, 1'b0);
    @(posedge clk); #1;
    check("irq_isr_edge", irq_o, 1'b0);
    @(posedge clk); #1;
    check("irq_rise", irq_o, 1'b1);
    rd_chk("isr_thr_set", ADDR_ISR, 32'h8C);
    rd_chk("rx_pop_a0", ADDR_RX_FIFO, 32'hA0);
    wr(ADDR_ISR, 32'h08);
    rd_chk("isr_thr_clr", ADDR_ISR, 32'h84);
    check("irq_fall", irq_o, 1'b0);
    for (int i = 1; i < 4; i++) rd_chk($sformatf("rx_pop_a%0d", i), ADDR_RX_FIFO, 32'(8'hA0 + i));

    // Set versus toggle on ISR
    evt_pulse(5'b00001);
    rd_chk("isr_evt0", ADDR_ISR, 32'h85);
    evt_i = 5'b00001;
    wr(ADDR_ISR, 32'h01);
    evt_i = '0;
    rd_chk("isr_set_wins", ADDR_ISR, 32'h85);
    wr(ADDR_ISR, 32'h01);
    rd_chk("isr_toggle_off", ADDR_ISR, 32'h84);
    wr(ADDR_ISR, 32'h01);
    rd_chk("isr_toggle_on", ADDR_ISR, 32'h85);
    evt_pulse(5'b11110);
    rd_chk("isr_evt_map", ADDR_ISR, 32'hF7);

    // Live status and TX FIFO reset bit
    sts_i = 4'hB;
    rd_chk("sr_sts", ADDR_SR, 32'hCB);
    sts_i = 4'h0;
    wr(ADDR_TX_FIFO, 32'h055);
    check("tx_one", {tx_valid_o, tx_data_o}, {1'b1, 10'h055});
    wr(ADDR_CR, 32'h02);
    wr(ADDR_TX_FIFO, 32'h066);
    check("tx_held_empty", tx_valid_o, 1'b0);
    wr(ADDR_CR, 32'h05);
    rd_chk("tx_ocy_held", ADDR_TX_OCY, 32'h0);
    rd_chk("sr_tx_held", ADDR_SR, 32'hC0);

    // TX overflow and soft reset
    wr(ADDR_GPO, 32'h5A5);
    for (int i = 0; i < 17; i++) wr(ADDR_TX_FIFO, 32'h100 + 32'(i));
    rd_chk("tx_ocy_full", ADDR_TX_OCY, 32'hF);
    rd_chk("sr_tx_full", ADDR_SR, 32'h50);
    check("tx_head_full", tx_data_o, 10'h100);
    wr(ADDR_SOFTR, 32'h5);
    check("softr_bad_key", soft_rst_o, 1'b0);
    rd_chk("cr_kept", ADDR_CR, 32'h05);
    rd_chk("tx_ocy_kept", ADDR_TX_OCY, 32'hF);
    wr(ADDR_SOFTR, 32'hA);
    check("softr_pulse", soft_rst_o, 1'b1);
    @(posedge clk); #1;
    check("softr_end", soft_rst_o, 1'b0);
    check("softr_ports", {cr_o, gpo_o, tx_valid_o, irq_o}, 64'h0);
    check("softr_timing", tsusta_o, T_RST);
    rd_chk("softr_cr", ADDR_CR, 32'h0);
    rd_chk("softr_sr", ADDR_SR, 32'hC0);
    rd_chk("softr_tx_ocy", ADDR_TX_OCY, 32'h0);
    rd_chk("softr_gpo", ADDR_GPO, 32'h0);
    rd_chk("softr_thddat", 9'h144, T_RST);

    // Report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
